serial_subtractor: RTL

Bit-serial N-bit subtractor that computes diff = a - b one bit per clock, LSB first, using a single registered borrow. It is the subtraction counterpart to the team's ripple-carry adder datapath, trading area for latency. The block sits behind a simple start/done handshake so that the lab FSMs can issue operations and collect the difference, borrow, overflow and zero flags.

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a single registered borrow.
// start/done handshake; diff, bout, ovf and zero are registered and held between operations.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             dbit;
  logic             br_next;
  logic [WIDTH-1:0] wr_shift;

  // Full-subtractor slice on the current LSBs.
  always_comb begin
    dbit     = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    wr_shift = {dbit, wr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    wr_d    = wr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          wr_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        wr_d = wr_shift;
        br_d = br_next;
        if (cnt_q == CntLast) begin
          // Last bit: publish the completed word, including this cycle's difference bit.
          cnt_d   = '0;
          diff_d  = wr_shift;
          bout_d  = br_next;
          zero_d  = ~|wr_shift;
          ovf_d   = (amsb_q != bmsb_q) && (wr_shift[WIDTH-1] != amsb_q);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      wr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      wr_q    <= wr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
